// File: rtl/sar_search_ctrl_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TEST = 2'd1, DONE = 2'd2} state_e;
  localparam int SAR_W_DEF = 8;
  localparam int SAR_IDX_W = $clog2(SAR_W_DEF);
endpackage

// File: rtl/comp_mag_n.sv
// Combinational magnitude comparator; partner block that closes the trial loop.
module comp_mag_n #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic         eq
);
  assign gt = (a > b);
  assign eq = (a == b);
endmodule

// File: rtl/sar_search_ctrl.sv
// MSB-first binary search of a target through an external comparator,
// stopping early when the comparator reports equality.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found_exact
);
  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] resolved;
  logic [IDXW-1:0]  bit_m1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= TOP_IDX;
      trial_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      found_q  <= found_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    trial_d  = trial_q;
    result_d = result_q;
    found_d  = found_q;
    bit_m1   = bit_q - 1'b1;
    // Current bit decided by the comparator; cmp_gt means the target lies above.
    resolved = trial_q;
    resolved[bit_q] = cmp_gt;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TEST;
          bit_d   = TOP_IDX;
          trial_d = {1'b1, {(WIDTH-1){1'b0}}};
          found_d = 1'b0;
        end
      end
      TEST: begin
        if (cmp_eq) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (bit_q == '0) begin
          result_d = resolved;
          state_d  = DONE;
        end else begin
          trial_d         = resolved;
          trial_d[bit_m1] = 1'b1;
          bit_d           = bit_m1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign trial       = trial_q;
  assign busy        = (state_q == TEST);
  assign done        = (state_q == DONE);
  assign result      = result_q;
  assign found_exact = found_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboarded bench: directed targets, expected trials/results queued by stimulus.
module tb_sar_search_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, cmp_gt, cmp_eq;
  logic [7:0] target, trial, result;
  logic       busy, done, found_exact;

  typedef struct {
    logic [7:0] res;
    logic       fnd;
    int         k;
  } exp_t;

  exp_t       rq[$];
  logic [7:0] tq[$];
  int         checks = 0;
  int         errors = 0;
  int         bcnt = 0;
  logic       done_prev = 1'b0;

  always #5 clk = ~clk;

  comp_mag_n #(.W(8)) u_cmp (.a(target), .b(trial), .gt(cmp_gt), .eq(cmp_eq));

  sar_search_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
    .trial(trial), .busy(busy), .done(done), .result(result), .found_exact(found_exact)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  // Monitor: checks every TEST-cycle trial and every done pulse against the queues.
  always @(negedge clk) begin
    if (busy) begin
      bcnt++;
      if (tq.size() == 0) fail_now("trial_extra");
      else chk("trial", {24'h0, trial}, {24'h0, tq.pop_front()});
    end
    if (!rst_n) begin
      bcnt      = 0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        if (rq.size() == 0) fail_now("done_unexpected");
        else begin
          exp_t e;
          e = rq.pop_front();
          chk("result", {24'h0, result}, {24'h0, e.res});
          chk("found_exact", {31'h0, found_exact}, {31'h0, e.fnd});
          chk("test_cycles", bcnt, e.k);
        end
        chk("busy_in_done", {31'h0, busy}, 32'h0);
        chk("done_one_cycle", {31'h0, done_prev}, 32'h0);
        bcnt = 0;
      end
      done_prev = done;
    end
  end

  task automatic push_exp(input logic [63:0] seq, input int k, input int ntr,
                          input logic [7:0] res, input logic fnd, input bit want_done);
    for (int i = 0; i < ntr; i++) tq.push_back(seq[63-8*i -: 8]);
    if (want_done) rq.push_back('{res: res, fnd: fnd, k: k});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
    end
    if (!done) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [7:0] t, input logic [63:0] seq, input int k,
                     input logic [7:0] res, input logic fnd);
    target = t;
    push_exp(seq, k, k, res, fnd, 1'b1);
    pulse_start();
    wait_done();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trial", {24'h0, trial}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_result", {24'h0, result}, 32'h0);
    chk("rst_found", {31'h0, found_exact}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8'h5A, 64'h80_40_60_50_58_5C_5A_00, 7, 8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_result", {24'h0, result}, 32'h5A);
    chk("held_found", {31'h0, found_exact}, 32'h1);
    chk("held_trial", {24'h0, trial}, 32'h5A);

    run(8'h80, 64'h80_00_00_00_00_00_00_00, 1, 8'h80, 1'b1);
    run(8'hFF, 64'h80_C0_E0_F0_F8_FC_FE_FF, 8, 8'hFF, 1'b1);
    run(8'h00, 64'h80_40_20_10_08_04_02_01, 8, 8'h00, 1'b0);

    // Start re-pulsed during the third TEST cycle must not disturb the search.
    target = 8'h33;
    push_exp(64'h80_40_20_30_38_34_32_33, 8, 8, 8'h33, 1'b1, 1'b1);
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    run(8'hC3, 64'h80_C0_E0_D0_C8_C4_C2_C3, 8, 8'hC3, 1'b1);

    // Reset asserted during the fourth TEST cycle aborts without a done pulse.
    target = 8'h77;
    push_exp(64'h80_40_60_70_00_00_00_00, 0, 4, 8'h00, 1'b0, 1'b0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_trial", {24'h0, trial}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_result", {24'h0, result}, 32'h0);
    chk("abort_found", {31'h0, found_exact}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", {31'h0, done}, 32'h0);
    run(8'h77, 64'h80_40_60_70_78_74_76_77, 8, 8'h77, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("trial_queue_empty", tq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
